// File: rtl/ex_ctrl_pkg.sv
// Shared EX-stage control definitions: op-kind codes, sequencer state encoding
// and a small elaboration-time helper.
package ex_ctrl_pkg;

    localparam logic [1:0] OPK_ALU  = 2'b00;
    localparam logic [1:0] OPK_MULT = 2'b01;
    localparam logic [1:0] OPK_DIV  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_WB   = 2'b10
    } state_t;

    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/mdu_cycle_counter.sv
// Down-counter tracking remaining MDU busy cycles. Clear beats load beats
// decrement; it never decrements through zero, so it cannot wrap.
module mdu_cycle_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clear,
    output logic         zero
);

    logic [W-1:0] cnt_r;

    // Counter register: clear, load, or guarded decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clear) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != {W{1'b0}})) begin
            cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/ex_mdu_sequencer.sv
// EX-stage multiply/divide sequencer. Accepts one MDU op at a time, holds the
// pipeline for the op's fixed latency and pulses the HI/LO write enable in the
// cycle after the MDU finishes. ALU ops pass straight through.
module ex_mdu_sequencer
    import ex_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [1:0] op_kind,
    input  logic       divisor_zero,
    input  logic       flush,
    output logic       stall,
    output logic       mdu_start,
    output logic       mdu_is_div,
    output logic       mdu_abort,
    output logic       hilo_we,
    output logic       busy,
    output logic       div_zero_err
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             is_mult_s;
    logic             is_div_s;
    logic             accept_s;
    logic             div_zero_hit_s;
    logic [CNT_W-1:0] load_val_s;
    logic             cnt_dec_s;
    logic             cnt_clear_s;
    logic             cnt_zero_s;
    logic             mdu_start_r;
    logic             mdu_is_div_r;
    logic             mdu_abort_r;
    logic             div_zero_err_r;

    // Op decode: what the ID/EX op would do if the sequencer could take it.
    always_comb begin
        is_mult_s      = op_valid & ~flush & (op_kind == OPK_MULT);
        is_div_s       = op_valid & ~flush & (op_kind == OPK_DIV);
        accept_s       = (state_r != ST_BUSY) & (is_mult_s | (is_div_s & ~divisor_zero));
        div_zero_hit_s = (state_r != ST_BUSY) & is_div_s & divisor_zero;
        if (op_kind == OPK_DIV) begin
            load_val_s = DIV_LOAD;
        end else begin
            load_val_s = MULT_LOAD;
        end
    end

    // Next-state logic and counter controls.
    always_comb begin
        state_nxt_s = state_r;
        cnt_dec_s   = 1'b0;
        cnt_clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                    cnt_clear_s = 1'b1;
                end else if (cnt_zero_s) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_BUSY;
                    cnt_dec_s   = 1'b1;
                end
            end
            ST_WB: begin
                if (accept_s) begin
                    state_nxt_s = ST_BUSY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered MDU handshakes and the sticky divide-by-zero flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            mdu_start_r    <= 1'b0;
            mdu_is_div_r   <= 1'b0;
            mdu_abort_r    <= 1'b0;
            div_zero_err_r <= 1'b0;
        end else begin
            mdu_start_r <= accept_s;
            mdu_abort_r <= (state_r == ST_BUSY) & flush;
            if (accept_s) begin
                mdu_is_div_r <= (op_kind == OPK_DIV);
            end else if (state_nxt_s == ST_IDLE) begin
                mdu_is_div_r <= 1'b0;
            end else begin
                mdu_is_div_r <= mdu_is_div_r;
            end
            if (div_zero_hit_s) begin
                div_zero_err_r <= 1'b1;
            end else begin
                div_zero_err_r <= div_zero_err_r;
            end
        end
    end

    mdu_cycle_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .load_val (load_val_s),
        .dec      (cnt_dec_s),
        .clear    (cnt_clear_s),
        .zero     (cnt_zero_s)
    );

    // Stall must cover the accepting cycle itself, so it is the one combinational output.
    assign stall        = (state_r == ST_BUSY) | accept_s;
    assign mdu_start    = mdu_start_r;
    assign mdu_is_div   = mdu_is_div_r;
    assign mdu_abort    = mdu_abort_r;
    assign hilo_we      = (state_r == ST_WB);
    assign busy         = (state_r != ST_IDLE);
    assign div_zero_err = div_zero_err_r;

endmodule

// File: tb/tb_ex_mdu_sequencer.sv
// Self-checking bench for ex_mdu_sequencer. Cycle 0 of each scenario is the
// first cycle after reset; inputs change 1 ns after a rising edge and outputs
// are sampled on the falling edge. HI/LO writebacks are scoreboarded.
module tb_ex_mdu_sequencer;
    import ex_ctrl_pkg::*;

    localparam int MC = 4;
    localparam int DC = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic [1:0] op_kind;
    logic       divisor_zero;
    logic       flush;
    logic       stall;
    logic       mdu_start;
    logic       mdu_is_div;
    logic       mdu_abort;
    logic       hilo_we;
    logic       busy;
    logic       div_zero_err;

    int errors = 0;
    int checks = 0;
    int hilo_q[$];

    ex_mdu_sequencer #(
        .MULT_CYCLES(MC),
        .DIV_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid     (op_valid),
        .op_kind      (op_kind),
        .divisor_zero (divisor_zero),
        .flush        (flush),
        .stall        (stall),
        .mdu_start    (mdu_start),
        .mdu_is_div   (mdu_is_div),
        .mdu_abort    (mdu_abort),
        .hilo_we      (hilo_we),
        .busy         (busy),
        .div_zero_err (div_zero_err)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [1:0] k, input logic dz,
                         input logic fl, input logic r);
        op_valid     = v;
        op_kind      = k;
        divisor_zero = dz;
        flush        = fl;
        rst          = r;
    endtask

    // Leaves time at posedge+1 with rst low: the current cycle is cycle 0.
    task automatic do_reset();
        drive(1'b0, OPK_ALU, 1'b0, 1'b0, 1'b1);
        hilo_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b0, OPK_ALU, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({stall, mdu_start, mdu_is_div, mdu_abort, hilo_we, busy, div_zero_err} !== 7'b0000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000000",
                     {stall, mdu_start, mdu_is_div, mdu_abort, hilo_we, busy, div_zero_err});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_mult_single();
        int exp_c;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            drive((c >= 10 && c <= 14), OPK_MULT, 1'b0, 1'b0, 1'b0);
            if (c == 10) hilo_q.push_back(10 + MC + 1);
            @(negedge clk);
            checks++;
            if (stall !== (c >= 10 && c <= 14)) begin
                errors++; $display("FAIL mult_stall: cycle %0d got %b", c, stall);
            end
            checks++;
            if (mdu_start !== (c == 11)) begin
                errors++; $display("FAIL mult_start: cycle %0d got %b", c, mdu_start);
            end
            checks++;
            if (busy !== (c >= 11 && c <= 15)) begin
                errors++; $display("FAIL mult_busy: cycle %0d got %b", c, busy);
            end
            if (hilo_we === 1'b1) begin
                checks++;
                if (hilo_q.size() == 0) begin
                    errors++; $display("FAIL mult_hilo: hilo_we at cycle %0d, expected none", c);
                end else begin
                    exp_c = hilo_q.pop_front();
                    if (c !== exp_c) begin
                        errors++; $display("FAIL mult_hilo: hilo_we at cycle %0d, expected %0d", c, exp_c);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hilo_q.size() != 0) begin
            errors++; $display("FAIL mult_hilo_missing: %0d pending, expected 0", hilo_q.size());
        end
    endtask

    task automatic test_div_single();
        int exp_c;
        int starts;
        starts = 0;
        do_reset();
        for (int c = 0; c <= 42; c++) begin
            drive((c >= 5 && c <= 37), OPK_DIV, 1'b0, 1'b0, 1'b0);
            if (c == 5) hilo_q.push_back(5 + DC + 1);
            @(negedge clk);
            checks++;
            if (stall !== (c >= 5 && c <= 37)) begin
                errors++; $display("FAIL div_stall: cycle %0d got %b", c, stall);
            end
            if (c >= 6 && c <= 37) begin
                checks++;
                if (mdu_is_div !== 1'b1) begin
                    errors++; $display("FAIL div_is_div: cycle %0d got %b expected 1", c, mdu_is_div);
                end
            end
            if (mdu_start === 1'b1) starts++;
            if (hilo_we === 1'b1) begin
                checks++;
                if (hilo_q.size() == 0) begin
                    errors++; $display("FAIL div_hilo: hilo_we at cycle %0d, expected none", c);
                end else begin
                    exp_c = hilo_q.pop_front();
                    if (c !== exp_c) begin
                        errors++; $display("FAIL div_hilo: hilo_we at cycle %0d, expected %0d", c, exp_c);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (starts !== 1) begin
            errors++; $display("FAIL div_start_count: got %0d expected 1", starts);
        end
        checks++;
        if (hilo_q.size() != 0) begin
            errors++; $display("FAIL div_hilo_missing: %0d pending, expected 0", hilo_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int exp_c;
        logic v;
        logic [1:0] k;
        do_reset();
        for (int c = 0; c <= 52; c++) begin
            v = (c >= 10 && c <= 47);
            k = (c >= 15) ? OPK_DIV : OPK_MULT;
            drive(v, k, 1'b0, 1'b0, 1'b0);
            if (c == 10) hilo_q.push_back(10 + MC + 1);
            if (c == 15) hilo_q.push_back(15 + DC + 1);
            @(negedge clk);
            checks++;
            if (stall !== (c >= 10 && c <= 47)) begin
                errors++; $display("FAIL b2b_stall: cycle %0d got %b", c, stall);
            end
            checks++;
            if (mdu_start !== (c == 11 || c == 16)) begin
                errors++; $display("FAIL b2b_start: cycle %0d got %b", c, mdu_start);
            end
            checks++;
            if (busy !== (c >= 11 && c <= 48)) begin
                errors++; $display("FAIL b2b_busy: cycle %0d got %b", c, busy);
            end
            if (c >= 11 && c <= 47) begin
                checks++;
                if (mdu_is_div !== (c >= 16)) begin
                    errors++; $display("FAIL b2b_is_div: cycle %0d got %b", c, mdu_is_div);
                end
            end
            if (hilo_we === 1'b1) begin
                checks++;
                if (hilo_q.size() == 0) begin
                    errors++; $display("FAIL b2b_hilo: hilo_we at cycle %0d, expected none", c);
                end else begin
                    exp_c = hilo_q.pop_front();
                    if (c !== exp_c) begin
                        errors++; $display("FAIL b2b_hilo: hilo_we at cycle %0d, expected %0d", c, exp_c);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hilo_q.size() != 0) begin
            errors++; $display("FAIL b2b_hilo_missing: %0d pending, expected 0", hilo_q.size());
        end
    endtask

    task automatic test_div_zero();
        do_reset();
        for (int c = 0; c <= 56; c++) begin
            drive((c == 3), OPK_DIV, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            checks++;
            if ({stall, mdu_start, busy, hilo_we} !== 4'b0000) begin
                errors++; $display("FAIL dz_quiet: cycle %0d stall/start/busy/hilo got %b expected 0000",
                                   c, {stall, mdu_start, busy, hilo_we});
            end
            checks++;
            if (div_zero_err !== (c >= 4)) begin
                errors++; $display("FAIL dz_err: cycle %0d got %b", c, div_zero_err);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_flush_busy();
        int exp_c;
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            drive((c >= 10 && c <= 12), OPK_MULT, 1'b0, (c == 12), 1'b0);
            if (c == 10) hilo_q.push_back(10 + MC + 1);
            if (c == 12) void'(hilo_q.pop_back());
            @(negedge clk);
            checks++;
            if (stall !== (c >= 10 && c <= 12)) begin
                errors++; $display("FAIL flush_stall: cycle %0d got %b", c, stall);
            end
            checks++;
            if (mdu_abort !== (c == 13)) begin
                errors++; $display("FAIL flush_abort: cycle %0d got %b", c, mdu_abort);
            end
            checks++;
            if (busy !== (c == 11 || c == 12)) begin
                errors++; $display("FAIL flush_busy: cycle %0d got %b", c, busy);
            end
            if (hilo_we === 1'b1) begin
                checks++;
                if (hilo_q.size() == 0) begin
                    errors++; $display("FAIL flush_hilo: hilo_we at cycle %0d, expected none", c);
                end else begin
                    exp_c = hilo_q.pop_front();
                    if (c !== exp_c) begin
                        errors++; $display("FAIL flush_hilo: hilo_we at cycle %0d, expected %0d", c, exp_c);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hilo_q.size() != 0) begin
            errors++; $display("FAIL flush_hilo_missing: %0d pending, expected 0", hilo_q.size());
        end
    endtask

    task automatic test_rst_mid_div();
        int exp_c;
        logic v;
        logic [1:0] k;
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            v = (c <= 7) || (c >= 12 && c <= 16);
            k = (c <= 7) ? OPK_DIV : OPK_MULT;
            drive(v, k, 1'b0, 1'b0, (c == 8));
            if (c == 0) hilo_q.push_back(0 + DC + 1);
            if (c == 8) void'(hilo_q.pop_back());
            if (c == 12) hilo_q.push_back(12 + MC + 1);
            @(negedge clk);
            checks++;
            if (stall !== ((c <= 8) || (c >= 12 && c <= 16))) begin
                errors++; $display("FAIL rst_stall: cycle %0d got %b", c, stall);
            end
            checks++;
            if (mdu_start !== (c == 1 || c == 13)) begin
                errors++; $display("FAIL rst_start: cycle %0d got %b", c, mdu_start);
            end
            if (c >= 9 && c <= 11) begin
                checks++;
                if ({stall, mdu_start, mdu_is_div, mdu_abort, hilo_we, busy, div_zero_err} !== 7'b0000000) begin
                    errors++; $display("FAIL rst_quiet: cycle %0d got %b expected 0000000",
                                       c, {stall, mdu_start, mdu_is_div, mdu_abort, hilo_we, busy, div_zero_err});
                end
            end
            if (hilo_we === 1'b1) begin
                checks++;
                if (hilo_q.size() == 0) begin
                    errors++; $display("FAIL rst_hilo: hilo_we at cycle %0d, expected none", c);
                end else begin
                    exp_c = hilo_q.pop_front();
                    if (c !== exp_c) begin
                        errors++; $display("FAIL rst_hilo: hilo_we at cycle %0d, expected %0d", c, exp_c);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hilo_q.size() != 0) begin
            errors++; $display("FAIL rst_hilo_missing: %0d pending, expected 0", hilo_q.size());
        end
    endtask

    // Flush during WB drops the new op but not the write-back; ALU/reserved ops never stall.
    task automatic test_flush_wb_alu();
        int exp_c;
        logic v;
        logic [1:0] k;
        do_reset();
        for (int c = 0; c <= 15; c++) begin
            v = (c >= 2 && c <= 7) || (c >= 9 && c <= 12);
            if (c >= 11) begin
                k = 2'b11;
            end else if (c >= 9) begin
                k = OPK_ALU;
            end else begin
                k = OPK_MULT;
            end
            drive(v, k, 1'b0, (c == 7), 1'b0);
            if (c == 2) hilo_q.push_back(2 + MC + 1);
            @(negedge clk);
            checks++;
            if (stall !== (c >= 2 && c <= 6)) begin
                errors++; $display("FAIL fwb_stall: cycle %0d got %b", c, stall);
            end
            checks++;
            if (mdu_start !== (c == 3)) begin
                errors++; $display("FAIL fwb_start: cycle %0d got %b", c, mdu_start);
            end
            checks++;
            if (busy !== (c >= 3 && c <= 7)) begin
                errors++; $display("FAIL fwb_busy: cycle %0d got %b", c, busy);
            end
            if (hilo_we === 1'b1) begin
                checks++;
                if (hilo_q.size() == 0) begin
                    errors++; $display("FAIL fwb_hilo: hilo_we at cycle %0d, expected none", c);
                end else begin
                    exp_c = hilo_q.pop_front();
                    if (c !== exp_c) begin
                        errors++; $display("FAIL fwb_hilo: hilo_we at cycle %0d, expected %0d", c, exp_c);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (hilo_q.size() != 0) begin
            errors++; $display("FAIL fwb_hilo_missing: %0d pending, expected 0", hilo_q.size());
        end
    endtask

    initial begin
        drive(1'b0, OPK_ALU, 1'b0, 1'b0, 1'b1);
        test_reset();
        test_mult_single();
        test_div_single();
        test_back_to_back();
        test_div_zero();
        test_flush_busy();
        test_rst_mid_div();
        test_flush_wb_alu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
